// File: rtl/operand_sequencer_if.sv
// Calculator display interface between the board inputs, the operand
// sequencer and the display driver.
//   SW, ENTER, OP, CHAIN : board inputs into the sequencer
//   A, B, R, ovf         : captured operands, result and signed overflow
//   state, done          : sequencer phase and "result showing" flag
// master = the sequencer; slave = whoever drives the board inputs and
// consumes the display values.
interface operand_sequencer_if;
    localparam int unsigned DW = 4;
    localparam int unsigned SW_W = 2;

    logic [DW-1:0]   SW;
    logic            ENTER;
    logic            OP;
    logic            CHAIN;
    logic [DW-1:0]   A;
    logic [DW-1:0]   B;
    logic [DW-1:0]   R;
    logic            ovf;
    logic [SW_W-1:0] state;
    logic            done;

    modport master (
        input  SW, ENTER, OP, CHAIN,
        output A, B, R, ovf, state, done
    );

    modport slave (
        output SW, ENTER, OP, CHAIN,
        input  A, B, R, ovf, state, done
    );
endinterface

// File: rtl/operand_sequencer.sv
// Operand sequencer: debounces ENTER, captures two 4-bit two's-complement
// operands from SW, computes A+B or A-B with signed overflow and holds the
// result for the display driver. In SHOW, a press may chain R in as the new A.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : operand_sequencer_if.master (SW/ENTER/OP/CHAIN in, A/B/R/ovf/state/done out)
module operand_sequencer #(
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned CW       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_sequencer_if.master    bus
);

    localparam int unsigned DW  = 4;
    localparam int unsigned XW  = DW + 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        CALC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    // Input conditioning state
    logic          sync1;
    logic          sync2;
    logic          db;
    logic [CW-1:0] cnt;
    logic          press;

    // Datapath / FSM state
    state_t        state_q, state_n;
    logic [DW-1:0] a_q, a_n;
    logic [DW-1:0] b_q, b_n;
    logic [DW-1:0] r_q, r_n;
    logic          ovf_q, ovf_n;
    logic          op_q, op_n;
    logic          done_q;
    logic [XW-1:0] ext_a;
    logic [XW-1:0] ext_b;
    logic [XW-1:0] s5;

    // Two-flop synchronizer and level debouncer; press pulses only on a 0->1 settle
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= bus.ENTER;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                db    <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Sign-extended 5-bit add/subtract; overflow when the top two bits disagree
    assign ext_a = {a_q[DW-1], a_q};
    assign ext_b = {b_q[DW-1], b_q};
    assign s5    = op_q ? (ext_a - ext_b) : (ext_a + ext_b);

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            op_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            r_q     <= r_n;
            ovf_q   <= ovf_n;
            op_q    <= op_n;
            done_q  <= (state_n == SHOW);
        end
    end

    // Next-state and next-data logic; a press during CALC is simply not consumed
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        r_n     = r_q;
        ovf_n   = ovf_q;
        op_n    = op_q;
        case (state_q)
            LOAD_A: begin
                if (press) begin
                    a_n     = bus.SW;
                    state_n = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_n     = bus.SW;
                    op_n    = bus.OP;
                    state_n = CALC;
                end
            end
            CALC: begin
                r_n     = s5[DW-1:0];
                ovf_n   = s5[XW-1] ^ s5[XW-2];
                state_n = SHOW;
            end
            SHOW: begin
                if (press) begin
                    a_n     = bus.CHAIN ? r_q : bus.SW;
                    state_n = LOAD_B;
                end
            end
            default: state_n = LOAD_A;
        endcase
    end

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.R     = r_q;
    assign bus.ovf   = ovf_q;
    assign bus.state = state_q;
    assign bus.done  = done_q;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Producer end of the calculator display interface: captures two 4-bit two's-complement operands from the switches on debounced ENTER presses.
- Computes R = A+B or A−B with signed overflow and holds A, B, R and ovf stable for the display driver.
- Sits between the board inputs (SW, KEY) and the display driver. Supports chaining the previous result in as the next A.

Parameters:
- DEBOUNCE, 16, number of consecutive cycles the synchronized ENTER level must hold a new value before the debounced level changes (minimum 1).
- CW, 5, debounce counter width; must satisfy 2^CW > DEBOUNCE.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- SW  input  4  operand value from switches, two's complement.
- ENTER  input  1  raw pushbutton, active-high, asynchronous to clk and bouncing.
- OP  input  1  0 = add, 1 = subtract; sampled on the press that captures B.
- CHAIN  input  1  sampled on a press in SHOW; 1 = reuse R as the new A.
- A  output  4  captured operand A.
- B  output  4  captured operand B.
- R  output  4  result, low 4 bits.
- ovf  output  1  signed overflow of the last computation.
- state  output  2  00 LOAD_A, 01 LOAD_B, 10 CALC, 11 SHOW.
- done  output  1  high exactly while state = SHOW.

Behaviour:
- Reset (rst=1 at a clock edge) clears all of the following; rst dominates every other event in that cycle and may land in any state:
  - A, B and R go to 0; ovf goes to 0; state goes to LOAD_A; done goes to 0.
  - Synchronizer flops go to 0, debounced level goes to 0, debounce counter goes to 0.
- Input conditioning:
  - ENTER passes through a 2-flop synchronizer giving signal s.
  - Counter behaviour: if s equals the debounced level db, the counter clears to 0. Otherwise the counter increments.
  - When the counter reaches DEBOUNCE−1 while s≠db, db takes the value of s and the counter clears.
  - press is a one-cycle pulse on the cycle db goes 0→1. No pulse is generated on release.
  - Bounces shorter than DEBOUNCE cycles never produce a press.
- The FSM acts on press in the cycle press is high; registers update at the next edge.
  - LOAD_A: on press, A←SW and state←LOAD_B. Otherwise hold.
  - LOAD_B: on press, B←SW, the op register←OP, and state←CALC.
  - CALC: unconditional, lasts 1 cycle.
    - Sign-extend A and B to 5 bits, then s5 = A+B (op=0) or A−B (op=1).
    - R←s5[3:0], ovf←s5[4]^s5[3], state←SHOW.
    - A press arriving during CALC is ignored and dropped.
  - SHOW: hold A, B, R and ovf. On press:
    - CHAIN=1: A←R and state←LOAD_B.
    - CHAIN=0: A←SW and state←LOAD_B.
    - R and ovf keep their values until the next CALC.
- Latency:
  - From the first cycle ENTER settles high to press: 2 (synchronizer) + DEBOUNCE cycles.
  - From press in LOAD_B to valid R/ovf: 2 clocks (CALC, then SHOW).
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- SW changing at any time other than a capturing press has no effect.
- Holding ENTER high produces a single press. A new press requires a release lasting at least DEBOUNCE cycles.
- Arithmetic boundaries:
  - 7+1 gives R=1000 with ovf=1.
  - −8−1 gives R=0111 with ovf=1.
  - 0−(−8) gives R=1000 with ovf=1.
  - −8+(−8) gives R=0000 with ovf=1.
  - −1+1 gives R=0000 with ovf=0.

Test Plan:
- Reset: drive rst high for 1 cycle mid-SHOW with A=3, R=5 → next cycle A=B=R=0, ovf=0, state=00, done=0.
- Debounce, DEBOUNCE=4:
  - ENTER toggles high for 3 cycles, low for 2, then high for 3 → no press and state stays 00.
  - ENTER held high for 10 cycles → exactly one capture, A←SW, occurring 6 cycles after the rise.
- Add with overflow: SW=0111 press, SW=0001 press with OP=0 → 2 cycles later state=11, R=1000, ovf=1, done=1.
- Subtract edge: A=0000, B=1000, OP=1 → R=1000, ovf=1. Repeat with A=1111, B=1111, OP=1 → R=0000, ovf=0.
- Chain: from SHOW with R=0101 and CHAIN=1, press → A=0101 and state=01. Then SW=0010, OP=1, press → R=0011, ovf=0.
- Held button across states: ENTER kept high after the B capture press → CALC→SHOW completes and no second capture occurs until ENTER is released and pressed again.
